// File: rtl/f1_start_ctrl.sv
// rtl/f1_start_ctrl.sv - F1 start-lights sequencer: lamp fill, LFSR-timed hold, go pulse.
module f1_start_ctrl #(
  parameter int unsigned STEP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_trigger,
  input  logic       i_abort,
  output logic [7:0] o_lights,
  output logic       o_busy,
  output logic       o_go,
  output logic [6:0] o_delay
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(STEP_TICKS);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:1] r_lfsr;
  logic [7:0] r_step;
  logic [7:0] w_step_nxt;
  logic [7:0] w_step_inc;
  logic [6:0] r_hold;
  logic [6:0] w_hold_nxt;
  logic [7:0] r_lights;
  logic [7:0] w_lights_nxt;
  logic       r_go;
  logic       w_go_nxt;
  logic [6:0] r_delay;
  logic [6:0] w_delay_nxt;

  assign w_step_inc = r_step + 8'd1;

  // LFSR free-runs regardless of state or tick strobe (x^7 + x^3 + 1)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 7'b0000001;
    end else begin
      r_lfsr <= {r_lfsr[6:1], r_lfsr[7] ^ r_lfsr[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_step   <= 8'd0;
      r_hold   <= 7'd0;
      r_lights <= 8'h00;
      r_go     <= 1'b0;
      r_delay  <= 7'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_hold   <= w_hold_nxt;
      r_lights <= w_lights_nxt;
      r_go     <= w_go_nxt;
      r_delay  <= w_delay_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_hold_nxt   = r_hold;
    w_lights_nxt = r_lights;
    w_go_nxt     = 1'b0;
    w_delay_nxt  = r_delay;
    case (r_state)
      S_IDLE: begin
        w_lights_nxt = 8'h00;
        // a coincident tick strobe is deliberately not counted here
        if (i_trigger) begin
          w_state_nxt = S_FILL;
          w_step_nxt  = 8'd0;
        end
      end
      S_FILL: begin
        if (i_abort) begin
          w_state_nxt  = S_IDLE;
          w_step_nxt   = 8'd0;
          w_hold_nxt   = 7'd0;
          w_lights_nxt = 8'h00;
        end else if (i_en) begin
          if (w_step_inc == STEP_LAST) begin
            w_step_nxt   = 8'd0;
            w_lights_nxt = {r_lights[6:0], 1'b1};
            if (r_lights == 8'h7F) begin
              w_delay_nxt = r_lfsr;
              w_hold_nxt  = r_lfsr;
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_step_nxt = w_step_inc;
          end
        end
      end
      S_HOLD: begin
        // abort beats a coincident final tick, so go is never raised by it
        if (i_abort) begin
          w_state_nxt  = S_IDLE;
          w_step_nxt   = 8'd0;
          w_hold_nxt   = 7'd0;
          w_lights_nxt = 8'h00;
        end else if (i_en) begin
          w_hold_nxt = r_hold - 7'd1;
          if (r_hold == 7'd1) begin
            w_state_nxt  = S_IDLE;
            w_lights_nxt = 8'h00;
            w_go_nxt     = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_step_nxt   = 8'd0;
        w_hold_nxt   = 7'd0;
        w_lights_nxt = 8'h00;
      end
    endcase
  end

  assign o_lights = r_lights;
  assign o_busy   = (r_state != S_IDLE);
  assign o_go     = r_go;
  assign o_delay  = r_delay;

  a_go_in_idle: assert property (@(posedge clk) disable iff (rst)
    o_go |-> (o_lights == 8'h00 && !o_busy));
  a_hold_full: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_HOLD) |-> (r_lights == 8'hFF));

endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb/tb_f1_start_ctrl.sv - bench for f1_start_ctrl with STEP_TICKS=1 and STEP_TICKS=3 instances.
module tb_f1_start_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, trig, abort;
  logic [7:0] l0, l1;
  logic       b0, b1, g0, g1;
  logic [6:0] d0, d1;

  f1_start_ctrl #(.STEP_TICKS(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_en(en), .i_trigger(trig), .i_abort(abort),
    .o_lights(l0), .o_busy(b0), .o_go(g0), .o_delay(d0)
  );

  f1_start_ctrl #(.STEP_TICKS(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_en(en), .i_trigger(trig), .i_abort(abort),
    .o_lights(l1), .o_busy(b1), .o_go(g1), .o_delay(d1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase 0 idle, 1 fill, 2 hold; lamps counts lit lamps
  int m_lfsr = 0;
  int ph[2], lamps[2], ticks[2], hold_left[2], dly[2], gov[2];
  int steps[2] = '{1, 3};

  typedef struct {
    logic       r, e, t, a;
    logic [7:0] lt;
    logic       bz, gz;
  } vec_t;
  vec_t tbl[$];

  function automatic int lfsr_next(input int v);
    return ((v << 1) & 'h7f) | (((v >> 6) ^ (v >> 2)) & 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int lb;
    lb = m_lfsr;
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        ph[s] = 0; lamps[s] = 0; ticks[s] = 0; hold_left[s] = 0; dly[s] = 0; gov[s] = 0;
      end else begin
        gov[s] = 0;
        case (ph[s])
          0: if (trig) begin ph[s] = 1; ticks[s] = 0; lamps[s] = 0; end
          1: begin
            if (abort) begin
              ph[s] = 0; lamps[s] = 0; ticks[s] = 0; hold_left[s] = 0;
            end else if (en) begin
              ticks[s]++;
              if (ticks[s] == steps[s]) begin
                ticks[s] = 0;
                lamps[s]++;
                if (lamps[s] == 8) begin
                  dly[s] = lb; hold_left[s] = lb; ph[s] = 2;
                end
              end
            end
          end
          default: begin
            if (abort) begin
              ph[s] = 0; lamps[s] = 0; ticks[s] = 0; hold_left[s] = 0;
            end else if (en) begin
              if (hold_left[s] == 1) begin
                lamps[s] = 0; gov[s] = 1; ph[s] = 0; hold_left[s] = 0;
              end else begin
                hold_left[s]--;
              end
            end
          end
        endcase
      end
    end
    m_lfsr = rst ? 1 : lfsr_next(lb);
  endtask

  task automatic compare();
    check("i1_lights", l0, ((1 << lamps[0]) - 1) & 'hff);
    check("i1_busy",   b0, ph[0] != 0);
    check("i1_go",     g0, gov[0]);
    check("i1_delay",  d0, dly[0]);
    check("i3_lights", l1, ((1 << lamps[1]) - 1) & 'hff);
    check("i3_busy",   b1, ph[1] != 0);
    check("i3_go",     g1, gov[1]);
    check("i3_delay",  d1, dly[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic add(input logic r, e, t, a, input logic [7:0] lt, input logic bz, gz);
    vec_t v;
    v.r = r; v.e = e; v.t = t; v.a = a; v.lt = lt; v.bz = bz; v.gz = gz;
    tbl.push_back(v);
  endtask

  task automatic run_to_hold(input int s, output bit ok);
    int n;
    n = 0;
    while (ph[s] != 2 && n < 400) begin
      cycle();
      trig = 1'b0;
      n++;
    end
    ok = (ph[s] == 2);
  endtask

  initial begin
    int lfsr_exp[5] = '{1, 2, 4, 9, 18};
    int n, last_change, n_int;
    bit ok;
    logic [7:0] prev_l;

    rst = 1'b1; en = 1'b0; trig = 1'b0; abort = 1'b0;
    cycle();
    cycle();

    // reset release, idle for 10 cycles
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) check("lfsr_model", m_lfsr, lfsr_exp[i]);
      cycle();
    end

    // STEP_TICKS=1 vector table
    add(1, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0, 8'h01, 1, 0);
    add(0, 1, 0, 0, 8'h03, 1, 0);
    add(0, 0, 0, 0, 8'h03, 1, 0);
    add(0, 1, 1, 0, 8'h07, 1, 0);
    add(0, 1, 0, 0, 8'h0F, 1, 0);
    add(0, 1, 0, 0, 8'h1F, 1, 0);
    add(0, 1, 0, 1, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 0, 1, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0, 8'h01, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; en = tbl[i].e; trig = tbl[i].t; abort = tbl[i].a;
      cycle();
      check($sformatf("tbl%0d_lights", i), l0, tbl[i].lt);
      check($sformatf("tbl%0d_busy", i),   b0, tbl[i].bz);
      check($sformatf("tbl%0d_go", i),     g0, tbl[i].gz);
    end

    // full run, en every cycle: HOLD lasts exactly delay cycles
    rst = 1'b0; abort = 1'b0; en = 1'b1; trig = 1'b1;
    run_to_hold(0, ok);
    check("full_reach_hold", ok, 1);
    n = 0;
    while (g0 !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    check("hold_len", n, dly[0]);
    check("go_lights_clear", l0, 8'h00);
    cycle();
    check("go_one_cycle", g0, 0);

    // STEP_TICKS=3, en every 4th clk: 12 clks per lamp, busy triggers ignored
    rst = 1'b1; en = 1'b0; cycle();
    rst = 1'b0;
    prev_l = 8'h00; last_change = -1; n_int = 0;
    for (int c = 0; c < 1500; c++) begin
      en = (c % 4 == 0);
      trig = (c == 0) || (ph[1] != 0 && $urandom_range(0, 9) == 0);
      cycle();
      if (l1 != prev_l && l1 != 8'h00) begin
        if (last_change >= 0) begin
          check("step_12clk", c - last_change, 12);
          n_int++;
        end
        last_change = c;
      end
      prev_l = l1;
      if (gov[1] != 0) break;
    end
    check("step_intervals", n_int, 7);
    check("slow_go_seen", g1, 1);
    trig = 1'b0;

    // abort coincident with final HOLD tick
    rst = 1'b1; cycle();
    rst = 1'b0; en = 1'b1; trig = 1'b1;
    run_to_hold(0, ok);
    check("abort_reach_hold", ok, 1);
    n = 0;
    while (hold_left[0] != 1 && n < 200) begin
      cycle();
      n++;
    end
    abort = 1'b1;
    cycle();
    check("abort_final_go", g0, 0);
    check("abort_final_lights", l0, 8'h00);
    check("abort_final_busy", b0, 0);
    abort = 1'b0;
    cycle();
    check("abort_final_go_after", g0, 0);

    // reset mid-HOLD, then a fresh run from the reset LFSR state
    rst = 1'b1; cycle();
    rst = 1'b0; trig = 1'b1;
    run_to_hold(0, ok);
    check("rst_reach_hold", ok, 1);
    cycle();
    rst = 1'b1;
    cycle();
    check("rst_lights", l0, 8'h00);
    check("rst_busy", b0, 0);
    check("rst_delay", d0, 0);
    rst = 1'b0; trig = 1'b1;
    run_to_hold(0, ok);
    check("rst_rerun_hold", ok, 1);
    check("rst_rerun_delay", d0, dly[0]);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 1) == 1);
      trig  = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
Sequencer for the F1 start-lights display, built around an internal 7-bit maximal-length LFSR.
- FILL phase: on a trigger, fills an 8-lamp bar one lamp per STEP_TICKS tick strobes.
- HOLD phase: holds all lamps on for a pseudo-random 1..127 ticks taken from the LFSR, then extinguishes all lamps and pulses go.
- Sits between the tick-rate clock divider (supplies en) and the lamp/reaction-timer logic (consumes lights and go).

Parameters:
STEP_TICKS, 1, tick strobes per lamp step in FILL; legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  tick strobe, one clk cycle wide; only FILL/HOLD timing advances on it
trigger  input  1  start request; level sampled every clk, acted on only in IDLE
abort  input  1  cancel sequence; returns to IDLE without go
lights  output  8  lamp bar; bit 0 lit first
busy  output  1  high in FILL and HOLD
go  output  1  one-cycle pulse on the edge where lights clear after HOLD
delay  output  7  delay value captured from the LFSR for the current/last HOLD

Behaviour:
- Reset values:
  - state=IDLE, lights=8'h00, busy=0, go=0, delay=7'd0.
  - step counter=0, hold counter=0, LFSR q[7:1]=7'b0000001.
  - rst has priority over everything, in any state.
- LFSR:
  - Free-runs every clk, not gated by en or by state.
  - Update: q <= {q[6:1], q[7]^q[3]}, i.e. x^7+x^3+1.
  - Period 127; all-zero state is unreachable.
- IDLE:
  - lights=0, busy=0.
  - trigger=1 -> FILL next cycle, step counter=0.
  - If en and trigger are coincident, the en is not counted.
- FILL:
  - Each en increments the step counter.
  - When the counter reaches STEP_TICKS: counter<=0 and lights<={lights[6:0],1'b1}.
  - On the step that sets lights to 8'hFF: delay<=q (the LFSR value before that edge), hold counter<=q, then go to HOLD.
  - Latency from trigger edge to lamp 0: exactly STEP_TICKS en strobes after FILL entry.
- HOLD:
  - lights=8'hFF.
  - Each en decrements the hold counter.
  - On the en where the counter equals 1: lights<=0, go<=1 for one cycle, state<=IDLE.
  - HOLD therefore lasts exactly delay en strobes.
- go:
  - Registered output; high only on the cycle after the final HOLD tick edge.
  - Never asserted by abort or rst.
- abort:
  - In FILL or HOLD: next cycle IDLE, lights=0, counters=0; delay retains its last value.
  - If abort and the final HOLD tick coincide, abort wins and go stays 0.
  - Ignored in IDLE.
- trigger:
  - Ignored while busy; no queuing.
  - A level held high through completion restarts FILL on the cycle after go.
- busy: 1 from the cycle after the accepted trigger until the cycle go asserts (or IDLE is re-entered after abort).
- Counter widths: step counter 8 bits, hold counter 7 bits. No wrap in legal operation.

Test Plan:
- Reset release, no stimulus, 10 cycles -> lights=0, busy=0, go=0, delay=0; the bench LFSR model matches 0000001, 0000010, 0000100, 0001001, 0010010 on successive cycles.
- STEP_TICKS=1, en every cycle, trigger pulse at cycle k -> lights progress 01,03,07,...,FF on consecutive cycles; delay equals the model LFSR value at the edge FF is set; go pulses exactly delay cycles later; lights return to 00 with go.
- STEP_TICKS=3, en every 4th clk -> each lamp step takes exactly 12 clks; triggers during FILL/HOLD are ignored (busy stays 1, sequence unchanged).
- Abort at lamp 5 (lights=1F) -> lights=00 next cycle, busy=0, go never asserts; a new trigger restarts from lights=00 with the step count cleared.
- Abort coincident with the final HOLD tick -> go=0, lights=00, state IDLE.
- rst asserted mid-HOLD -> all outputs at reset values next cycle; LFSR back to 0000001.
